lm_sm_sequencer: RTL and testbench

Memory-side initiator for the multi-register load/store instructions (LM/SM). Given a base address and an 8-bit register list, it walks the list from R0 upward and issues one RAM word access per set bit. Addresses are consecutive, starting at the base. It drives the data-memory write port (address, inp, load) and the register-file ports. It sits between the control FSM and the data memory/register file, so the control FSM only issues start and waits for done.

---
 rtl/lm_sm_sequencer.sv | 129 ++++++++++++
 tb/tb_lm_sm_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lm_sm_sequencer.sv
// Purpose : walks an 8-bit register list for LM/SM, issuing one RAM word access
//           per set bit at consecutive addresses starting at base_addr.
// Latency : start at edge 0 -> transfers in cycles 1..N -> done in cycle N+1
//           (N = popcount(reg_list); done in cycle 1 when the list is empty).
// Backpressure: none; start is only accepted in IDLE and is dropped otherwise.
//
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   start/is_store/base_addr/reg_list   request, sampled only when accepted
//   ram_outp, rf_rdata          combinational read data from memory / regfile
//   ram_address/ram_inp/ram_load        data-memory write port (SM)
//   rf_raddr/rf_waddr/rf_wdata/rf_we    register-file ports (LM reads RAM into Ri)
//   busy, done                  status; done is a one-cycle pulse
module lm_sm_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NREG-1:0]   reg_list,
    input  logic [DATA_W-1:0] ram_outp,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_inp,
    output logic              ram_load,
    output logic [IDX_W-1:0]  rf_raddr,
    output logic [IDX_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_rest;
    logic [ADDR_W-1:0] addr;
    logic              op;
    logic [IDX_W-1:0]  idx;

    // Lowest set bit of the pending list; scanning downward lets the
    // lowest index win. Yields 0 when nothing is pending.
    always_comb begin
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // Pending list with its lowest set bit removed.
    assign pending_rest = pending & (pending - NREG'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
            addr    <= '0;
            op      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        pending <= reg_list;
                        addr    <= base_addr;
                        op      <= is_store;
                    end
                end
                XFER: begin
                    pending <= pending_rest;
                    addr    <= addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Next state and strobes; strobes depend only on registered state so
    // they cannot glitch with the request inputs.
    always_comb begin
        state_nxt = state;
        ram_load  = 1'b0;
        rf_we     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (reg_list != '0) ? XFER : DONE;
                end
            end
            XFER: begin
                busy     = 1'b1;
                ram_load = op;
                rf_we    = ~op;
                if (pending_rest == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ram_address = addr;
    assign rf_raddr    = idx;
    assign rf_waddr    = idx;
    assign ram_inp     = rf_rdata;
    assign rf_wdata    = ram_outp;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Scoreboard bench for lm_sm_sequencer: a list-walking reference model pushes
// expected accesses and done cycles; a negedge monitor pops and compares.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [15:0] base_addr = '0;
    logic [7:0]  reg_list = '0;
    logic [15:0] ram_outp;
    logic [15:0] rf_rdata;
    logic [15:0] ram_address;
    logic [15:0] ram_inp;
    logic        ram_load;
    logic [2:0]  rf_raddr;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rf_we;
    logic        busy;
    logic        done;

    lm_sm_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_store   (is_store),
        .base_addr  (base_addr),
        .reg_list   (reg_list),
        .ram_outp   (ram_outp),
        .rf_rdata   (rf_rdata),
        .ram_address(ram_address),
        .ram_inp    (ram_inp),
        .ram_load   (ram_load),
        .rf_raddr   (rf_raddr),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_we      (rf_we),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory and register file seen by the DUT.
    logic [15:0] mem [0:65535];
    logic [15:0] rf  [0:7];
    assign ram_outp = mem[ram_address];
    assign rf_rdata = rf[rf_raddr];
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_inp;
        if (rf_we)    rf[rf_waddr]     <= rf_wdata;
    end

    // Reference copies updated by the model.
    logic [15:0] ref_mem [0:65535];
    logic [15:0] ref_rf  [0:7];

    typedef struct {
        bit          st;
        logic [15:0] addr;
        logic [2:0]  idx;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   busy_lo = 1;
    int   busy_hi = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            exp_t e;
            chk("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
            if (ram_load || rf_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_access", 64'({ram_load, rf_we}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind", 64'({ram_load, rf_we}), 64'({e.st, ~e.st}));
                    chk("access_cycle", 64'(cyc), 64'(e.cyc));
                    chk("address", 64'(ram_address), 64'(e.addr));
                    chk("reg_index", 64'({rf_raddr, rf_waddr}), 64'({e.idx, e.idx}));
                    chk("data", 64'(e.st ? ram_inp : rf_wdata), 64'(e.data));
                end
            end
            if (done) begin
                if (done_q.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
                else                    chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
            end
        end
    end

    // Issue a request; the model applies at most 'limit' transfers (used when
    // a reset will cut the operation short) and then expects no done.
    task automatic issue(input bit st, input logic [15:0] base, input logic [7:0] list,
                         input int limit, output int s);
        int k;
        @(negedge clk);
        start = 1'b1; is_store = st; base_addr = base; reg_list = list;
        @(posedge clk);
        #1;
        s = cyc;
        start = 1'b0;
        is_store = 1'($urandom); base_addr = 16'($urandom); reg_list = 8'($urandom);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (list[i]) begin
                if (k < limit) begin
                    exp_t e;
                    e.st   = st;
                    e.addr = base + 16'(k);
                    e.idx  = 3'(i);
                    e.data = st ? ref_rf[i] : ref_mem[e.addr];
                    e.cyc  = s + k;
                    if (st) ref_mem[e.addr] = e.data;
                    else    ref_rf[i]       = e.data;
                    exp_q.push_back(e);
                end
                k++;
            end
        end
        if (k <= limit) done_q.push_back(s + k);
        busy_lo = s;
        busy_hi = s + k;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && t < 60) begin
            @(posedge clk);
            t++;
        end
        chk({name, "_timeout"}, 64'(t < 60), 64'd1);
        @(posedge clk);
    endtask

    task automatic check_mem(input string name);
        int diffs = 0;
        for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) diffs++;
        for (int r = 0; r < 8; r++) if (rf[r] !== ref_rf[r]) diffs++;
        chk(name, 64'(diffs), 64'd0);
    endtask

    initial begin
        int s;
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 16'($urandom);
            ref_mem[a] = mem[a];
        end
        for (int r = 0; r < 8; r++) begin
            rf[r] = 16'($urandom);
            ref_rf[r] = rf[r];
        end

        #1;
        chk("reset_outputs", 64'({ram_address, ram_load, rf_we, rf_raddr, rf_waddr, busy, done}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: SM R0/R2/R7 to 0x10..0x12
        rf[0] = 16'h1111; rf[2] = 16'h2222; rf[7] = 16'h7777;
        ref_rf[0] = 16'h1111; ref_rf[2] = 16'h2222; ref_rf[7] = 16'h7777;
        issue(1'b1, 16'h0010, 8'b1000_0101, 8, s);
        wait_done("sm_sparse");
        chk("ram_0x12", 64'(mem[16'h0012]), 64'h7777);

        // 2: LM full list
        for (int i = 0; i < 8; i++) begin
            mem[16'h0020 + 16'(i)] = 16'hA000 + 16'(i);
            ref_mem[16'h0020 + 16'(i)] = 16'hA000 + 16'(i);
        end
        issue(1'b0, 16'h0020, 8'hFF, 8, s);
        wait_done("lm_full");
        chk("r5_after_lm", 64'(rf[5]), 64'hA005);

        // 3: empty list, both ops
        issue(1'b1, 16'h1234, 8'h00, 8, s);
        wait_done("empty_sm");
        issue(1'b0, 16'h4321, 8'h00, 8, s);
        wait_done("empty_lm");

        // 4: address wrap
        issue(1'b1, 16'hFFFE, 8'h07, 8, s);
        wait_done("wrap");

        // 5: start pulses during XFER and DONE are ignored
        issue(1'b1, 16'h0300, 8'h0F, 8, s);
        repeat (7) begin
            @(negedge clk);
            start = (cyc == s + 1) || (cyc == s + 4);
            reg_list = 8'hFF;
        end
        start = 1'b0;
        wait_done("ignore_start");

        check_mem("contents_directed");

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [7:0]  list;
            logic [15:0] base;
            case ($urandom_range(0, 4))
                0:       list = 8'h00;
                1:       list = 8'hFF;
                default: list = 8'($urandom);
            endcase
            base = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                                : 16'($urandom);
            issue(1'($urandom), base, list, 8, s);
            wait_done("random");
        end
        check_mem("contents_random");

        // 6: reset in the middle of an SM after two writes
        issue(1'b1, 16'h0040, 8'h0F, 2, s);
        @(posedge clk);
        @(posedge clk);
        #2;
        busy_lo = 1;
        busy_hi = 0;
        reset = 1'b1;
        #1;
        chk("reset_mid_op", 64'({ram_load, rf_we, busy, done}), 64'd0);
        chk("reset_mid_addr", 64'(ram_address), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        issue(1'b0, 16'h0100, 8'h01, 8, s);
        wait_done("after_reset");
        check_mem("contents_after_reset");

        chk("leftover_accesses", 64'(exp_q.size()), 64'd0);
        chk("leftover_done", 64'(done_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
